// File: rtl/pulse_gen.sv
// Programmable pulse source: after an accepted start it emits single-cycle pulses
// every PERIOD clocks, either a fixed count or continuously, with pause/abort control.
module pulse_gen #(
  parameter int PW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pause,
  input  logic          abort,
  input  logic [PW-1:0] period,
  input  logic [CW-1:0] num_pulses,
  output logic          pulse,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] sent
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t        state;
  logic [PW-1:0] timer;
  logic [PW-1:0] p_lat;
  logic [CW-1:0] n_lat;

  logic [PW-1:0] p_eff;
  logic [CW-1:0] sent_nxt;

  // A zero period would never let the timer expire, so it behaves as 1.
  assign p_eff    = (period == '0) ? PW'(1) : period;
  assign sent_nxt = sent + CW'(1);
  assign busy     = (state == RUN) || (state == HOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
      p_lat <= '0;
      n_lat <= '0;
      sent  <= '0;
      pulse <= 1'b0;
      done  <= 1'b0;
    end else begin
      // NOTE: pulse and done default low every edge and are raised only where
      // needed; non-blocking assignments let later branches override the default.
      pulse <= 1'b0;
      done  <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            done <= (state == DONE);
            if (start && !pause) begin
              state <= RUN;
              p_lat <= p_eff;
              n_lat <= num_pulses;
              timer <= p_eff - PW'(1);
              sent  <= '0;
            end else begin
              state <= IDLE;
            end
          end
          RUN: begin
            if (pause) begin
              state <= HOLD;
            end else if (timer == '0) begin
              pulse <= 1'b1;
              sent  <= sent_nxt;
              timer <= p_lat - PW'(1);
              if (n_lat != '0 && sent_nxt == n_lat) state <= DONE;
            end else begin
              timer <= timer - PW'(1);
            end
          end
          HOLD: begin
            // Timer stays frozen, so the remaining interval survives the pause.
            if (!pause) state <= RUN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Scoreboard bench for pulse_gen: stimulus queues expected pulse/done cycles,
// a negedge monitor pops and compares them whenever the DUT raises an output.
module tb_pulse_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] period = '0;
  logic [7:0] num_pulses = '0;
  logic       pulse;
  logic       busy;
  logic       done;
  logic [7:0] sent;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int pulse_q[$];
  int done_q[$];
  int exp_p;
  int exp_d;

  pulse_gen #(.PW(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .period(period), .num_pulses(num_pulses),
    .pulse(pulse), .busy(busy), .done(done), .sent(sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic launch(input int per, input int num, output int e0);
    period     = 8'(per);
    num_pulses = 8'(num);
    start      = 1'b1;
    tick();
    e0    = cyc;
    start = 1'b0;
  endtask

  // Monitor: every observed pulse/done must match the next queued cycle.
  always @(negedge clk) begin
    if (pulse) begin
      if (pulse_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_p = pulse_q.pop_front();
        check("pulse_cycle", cyc, exp_p);
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_d = done_q.pop_front();
        check("done_cycle", cyc, exp_d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;

    // Reset state
    tick();
    tick();
    check("rst_pulse", pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sent", sent, 0);
    rst = 1'b1;
    tick();

    // 1: period 3, four pulses
    launch(3, 4, e0);
    check("t1_busy", busy, 1);
    for (int k = 1; k <= 4; k++) pulse_q.push_back(e0 + 3 * k);
    done_q.push_back(e0 + 13);
    wait_to(e0 + 13);
    check("t1_busy_end", busy, 0);
    wait_to(e0 + 15);
    check("t1_sent", sent, 4);

    // 2: period 0 acts as 1
    launch(0, 3, e0);
    for (int k = 1; k <= 3; k++) pulse_q.push_back(e0 + k);
    done_q.push_back(e0 + 4);
    wait_to(e0 + 6);
    check("t2_sent", sent, 3);

    // 3: pause while timer is at zero preserves the due pulse
    launch(4, 5, e0);
    pulse_q.push_back(e0 + 4);
    pulse_q.push_back(e0 + 15);
    pulse_q.push_back(e0 + 19);
    pulse_q.push_back(e0 + 23);
    pulse_q.push_back(e0 + 27);
    done_q.push_back(e0 + 28);
    wait_to(e0 + 7);
    pause = 1'b1;
    wait_to(e0 + 10);
    check("t3_busy_hold", busy, 1);
    check("t3_sent_hold", sent, 1);
    wait_to(e0 + 13);
    pause = 1'b0;
    wait_to(e0 + 30);
    check("t3_sent", sent, 5);
    check("t3_busy_end", busy, 0);

    // 4: continuous at period 1 for 300 pulses, then abort
    launch(1, 0, e0);
    for (int k = 1; k <= 300; k++) pulse_q.push_back(e0 + k);
    wait_to(e0 + 300);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_busy_abort", busy, 0);
    wait_to(e0 + 305);
    check("t4_sent_wrap", sent, 44);

    // 5a: abort after three pulses
    launch(5, 10, e0);
    for (int k = 1; k <= 3; k++) pulse_q.push_back(e0 + 5 * k);
    wait_to(e0 + 15);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy_abort", busy, 0);
    wait_to(e0 + 30);
    check("t5_sent_abort", sent, 3);

    // 5b: asynchronous reset while a pulse is high
    launch(2, 10, e0);
    pulse_q.push_back(e0 + 2);
    wait_to(e0 + 4);
    check("t5_pulse_pre_rst", pulse, 1);
    check("t5_sent_pre_rst", sent, 2);
    rst = 1'b0;
    #1;
    check("t5_rst_pulse", pulse, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_sent", sent, 0);
    check("t5_rst_done", done, 0);
    tick();
    tick();
    rst = 1'b1;
    repeat (4) tick();
    check("t5_idle_after_rst", busy, 0);

    // 5c: restart after reset
    launch(2, 2, e0);
    check("t5_restart_sent", sent, 0);
    pulse_q.push_back(e0 + 2);
    pulse_q.push_back(e0 + 4);
    done_q.push_back(e0 + 5);
    wait_to(e0 + 7);
    check("t5_restart_final", sent, 2);

    // 6: start blocked by pause, then accepted; period change mid-run ignored
    period     = 8'd3;
    num_pulses = 8'd3;
    start      = 1'b1;
    pause      = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t6_blocked_busy", busy, 0);
    end
    pause = 1'b0;
    tick();
    e0 = cyc;
    start = 1'b0;
    check("t6_busy", busy, 1);
    period = 8'd7;
    for (int k = 1; k <= 3; k++) pulse_q.push_back(e0 + 3 * k);
    done_q.push_back(e0 + 10);
    wait_to(e0 + 12);
    check("t6_sent", sent, 3);
    check("t6_busy_end", busy, 0);

    check("pulse_q_empty", pulse_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
